// File: rtl/mem_access_ctrl.sv
// Memory-port sequencer: turns one read/write request into the MAR -> MDR -> memory
// strobe sequence, waits on mem_ready with a bounded timeout, and pulses done/err.
module mem_access_ctrl #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic clr,
  input  logic req_rd,
  input  logic req_wr,
  input  logic mem_ready,
  output logic mar_en,
  output logic mdr_en,
  output logic mdr_read,
  output logic mem_rd,
  output logic mem_wr,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_op, w_op_nxt;
  logic             r_err, w_err_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_op    <= 1'b1;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;
    mar_en      = 1'b0;
    mdr_en      = 1'b0;
    mdr_read    = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    err         = 1'b0;

    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        // Read wins a tie; a held write request is picked up after the read.
        if (req_rd) begin
          w_op_nxt    = 1'b1;
          w_state_nxt = S_ADDR;
        end else if (req_wr) begin
          w_op_nxt    = 1'b0;
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        mar_en      = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = r_op ? S_ACCESS : S_DATA;
      end
      S_DATA: begin
        mdr_en      = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        mem_rd = r_op;
        mem_wr = ~r_op;
        if (mem_ready) begin
          // Read data is captured into MDR in the same cycle memory reports ready.
          mdr_en      = r_op;
          mdr_read    = r_op;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_DONE;
        end else if (w_cnt_inc == TMO_LIMIT) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        err         = r_err;
        w_state_nxt = S_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
